// File: rtl/vc_output_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one output link among NUM_VC credit-controlled VC buffers.
// Optional VC_ARB_STATS_EN adds per-VC grant counters and a link stall counter.
module vc_output_arbiter #(
  parameter int NUM_VC       = 4,
  parameter int FLIT_WIDTH   = 64,
  parameter int CREDIT_DEPTH = 8,
  parameter int VC_W         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_VC-1:0]            vc_empty,
  input  logic [NUM_VC*FLIT_WIDTH-1:0] vc_flit,
  output logic [NUM_VC-1:0]            vc_consume,
  output logic                         out_valid,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic [VC_W-1:0]              out_vc,
  input  logic                         out_ready,
  input  logic                         credit_valid,
  input  logic [VC_W-1:0]              credit_vc,
  output logic                         busy
`ifdef VC_ARB_STATS_EN
  ,
  output logic [NUM_VC*32-1:0]         grant_cnt,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [VC_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [VC_W-1:0]       locked_vc_q, locked_vc_d;
  logic [VC_W-1:0]       grant_vc, cand;
  logic                  pop, found, slot_free;
  logic [NUM_VC-1:0]     eligible, head_flag, tail_flag;
  logic [FLIT_WIDTH-1:0] flits [NUM_VC];
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  out_valid_q;
  logic [FLIT_WIDTH-1:0] out_flit_q;
  logic [VC_W-1:0]       out_vc_q;

  function automatic logic [VC_W-1:0] wrap_add(input logic [VC_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_VC) s = s - NUM_VC;
    return VC_W'(s);
  endfunction

  assign slot_free = ~out_valid_q | out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic [CW-1:0] credit_q;
      logic          credit_inc, credit_dec;

      assign flits[gi]      = vc_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
      assign head_flag[gi]  = flits[gi][FLIT_WIDTH-1];
      assign tail_flag[gi]  = flits[gi][FLIT_WIDTH-2];
      assign eligible[gi]   = ~vc_empty[gi] & (credit_q != '0);
      assign vc_consume[gi] = pop & (grant_vc == VC_W'(gi));

      assign credit_dec = vc_consume[gi];
      assign credit_inc = credit_valid & (credit_vc == VC_W'(gi));

      // Simultaneous pop and return cancel; returns beyond the depth are dropped.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          credit_q <= CW'(CREDIT_DEPTH);
        end else if (credit_dec & ~credit_inc) begin
          credit_q <= credit_q - 1'b1;
        end else if (credit_inc & ~credit_dec & (credit_q != CW'(CREDIT_DEPTH))) begin
          credit_q <= credit_q + 1'b1;
        end
      end
    end
  endgenerate

  assign sel_flit = flits[grant_vc];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    locked_vc_d = locked_vc_q;
    grant_vc    = '0;
    cand        = '0;
    pop         = 1'b0;
    found       = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free) begin
          for (int k = 0; k < NUM_VC; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            // Body flits left at a buffer head never start a packet.
            if (!found && eligible[cand] && head_flag[cand]) begin
              found    = 1'b1;
              grant_vc = cand;
            end
          end
          if (found) begin
            pop         = 1'b1;
            locked_vc_d = grant_vc;
            if (tail_flag[grant_vc]) begin
              rr_ptr_d = wrap_add(grant_vc, 1);
            end else begin
              state_d = SEND;
            end
          end
        end
      end
      SEND: begin
        grant_vc = locked_vc_q;
        if (slot_free && eligible[locked_vc_q]) begin
          pop = 1'b1;
          if (tail_flag[locked_vc_q]) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_add(locked_vc_q, 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      locked_vc_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_vc_q <= locked_vc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_vc_q    <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_flit_q  <= sel_flit;
      out_vc_q    <= grant_vc;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign out_vc    = out_vc_q;
  assign busy      = (state_q == SEND);

`ifdef VC_ARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] grant_cnt_q [NUM_VC];

  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_stats
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          grant_cnt_q[gi] <= '0;
        end else if (vc_consume[gi] & head_flag[gi]) begin
          grant_cnt_q[gi] <= grant_cnt_q[gi] + 32'd1;
        end
      end
      assign grant_cnt[gi*32 +: 32] = grant_cnt_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q & ~out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter: per-VC buffers are modelled with queues that pop on vc_consume.
module tb_vc_output_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   vc_empty;
  logic [255:0] vc_flit;
  logic [3:0]   vc_consume;
  logic         out_valid;
  logic [63:0]  out_flit;
  logic [1:0]   out_vc;
  logic         out_ready;
  logic         credit_valid;
  logic [1:0]   credit_vc;
  logic         busy;

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  cons;
  logic [63:0] fifo [4][$];

  vc_output_arbiter #(
    .NUM_VC(4), .FLIT_WIDTH(64), .CREDIT_DEPTH(8), .VC_W(2)
  ) dut (
    .clk(clk), .rst(rst), .vc_empty(vc_empty), .vc_flit(vc_flit), .vc_consume(vc_consume),
    .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc), .out_ready(out_ready),
    .credit_valid(credit_valid), .credit_vc(credit_vc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input bit h, input bit t, input int vc, input int seq);
    return {h, t, 62'(vc * 256 + seq)};
  endfunction

  task automatic update_inputs();
    for (int i = 0; i < 4; i++) begin
      vc_empty[i]        = (fifo[i].size() == 0);
      vc_flit[i*64 +: 64] = (fifo[i].size() == 0) ? 64'h0 : fifo[i][0];
    end
  endtask

  task automatic push(input int vc, input logic [63:0] f);
    fifo[vc].push_back(f);
    update_inputs();
  endtask

  // Called at a negedge; returns at the next negedge with the cycle's pops applied.
  task automatic tick();
    #1;
    cons = vc_consume;
    @(posedge clk);
    #1;
    credit_valid = 1'b0;
    for (int i = 0; i < 4; i++) if (cons[i]) void'(fifo[i].pop_front());
    update_inputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    credit_valid = 1'b0;
    credit_vc    = 2'd0;
    out_ready    = 1'b1;
    for (int i = 0; i < 4; i++) fifo[i].delete();
    update_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_flit", out_flit, 64'h0);
    check("rst_out_vc", 64'(out_vc), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_consume", 64'(vc_consume), 64'h0);

    // 1: single-flit packet on VC0, one-cycle latency
    push(0, mk(1, 1, 0, 1));
    #1;
    check("t1_consume", 64'(vc_consume), 64'h1);
    tick();
    check("t1_out_valid", 64'(out_valid), 64'h1);
    check("t1_out_flit", out_flit, mk(1, 1, 0, 1));
    check("t1_out_vc", 64'(out_vc), 64'h0);
    check("t1_busy", 64'(busy), 64'h0);
    tick();
    check("t1_drain", 64'(out_valid), 64'h0);

    // 2: round-robin order across all VCs, pointer wraps to 0
    do_reset();
    for (int v = 0; v < 4; v++) push(v, mk(1, 1, v, 2));
    for (int v = 0; v < 4; v++) begin
      tick();
      check($sformatf("t2_grant%0d", v), 64'(cons), 64'(4'b0001 << v));
      check($sformatf("t2_out_vc%0d", v), 64'(out_vc), 64'(v));
    end
    push(3, mk(1, 1, 3, 3));
    push(0, mk(1, 1, 0, 3));
    tick();
    check("t2_rr_wrap", 64'(cons), 64'h1);

    // 3: wormhole lock on VC1 while VC2 waits
    do_reset();
    push(1, mk(1, 0, 1, 10));
    push(1, mk(0, 0, 1, 11));
    push(1, mk(0, 1, 1, 12));
    tick();
    check("t3_head_grant", 64'(cons), 64'h2);
    check("t3_head_flit", out_flit, mk(1, 0, 1, 10));
    check("t3_busy_head", 64'(busy), 64'h1);
    push(2, mk(1, 1, 2, 13));
    tick();
    check("t3_body_grant", 64'(cons), 64'h2);
    check("t3_body_flit", out_flit, mk(0, 0, 1, 11));
    check("t3_busy_body", 64'(busy), 64'h1);
    tick();
    check("t3_tail_grant", 64'(cons), 64'h2);
    check("t3_tail_flit", out_flit, mk(0, 1, 1, 12));
    check("t3_busy_tail", 64'(busy), 64'h0);
    tick();
    check("t3_vc2_grant", 64'(cons), 64'h4);
    check("t3_vc2_out_vc", 64'(out_vc), 64'h2);

    // 4: credit exhaustion on VC3 and recovery by a single returned credit
    do_reset();
    for (int k = 0; k < 9; k++) push(3, mk(1, 1, 3, k));
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t4_pop%0d", k), 64'(cons), 64'h8);
    end
    #1;
    check("t4_no_credit", 64'(vc_consume), 64'h0);
    tick();
    check("t4_stall_cycle", 64'(cons), 64'h0);
    check("t4_out_drained", 64'(out_valid), 64'h0);
    credit_valid = 1'b1;
    credit_vc    = 2'd3;
    #1;
    check("t4_credit_not_yet", 64'(vc_consume), 64'h0);
    tick();
    #1;
    check("t4_after_credit", 64'(vc_consume), 64'h8);
    tick();
    check("t4_ninth_flit", out_flit, mk(1, 1, 3, 8));
    check("t4_ninth_valid", 64'(out_valid), 64'h1);

    // 5: link back-pressure holds the output register
    do_reset();
    push(0, mk(1, 0, 0, 20));
    push(0, mk(0, 0, 0, 21));
    push(0, mk(0, 1, 0, 22));
    tick();
    check("t5_head_flit", out_flit, mk(1, 0, 0, 20));
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t5_hold_consume%0d", k), 64'(vc_consume), 64'h0);
      tick();
      check($sformatf("t5_hold_flit%0d", k), out_flit, mk(1, 0, 0, 20));
      check($sformatf("t5_hold_valid%0d", k), 64'(out_valid), 64'h1);
    end
    out_ready = 1'b1;
    #1;
    check("t5_resume_consume", 64'(vc_consume), 64'h1);
    tick();
    check("t5_body_flit", out_flit, mk(0, 0, 0, 21));
    tick();
    check("t5_tail_flit", out_flit, mk(0, 1, 0, 22));
    check("t5_busy", 64'(busy), 64'h0);

    // 6: asynchronous reset in the middle of a packet
    do_reset();
    push(1, mk(1, 0, 1, 30));
    push(1, mk(0, 0, 1, 31));
    push(1, mk(0, 1, 1, 32));
    tick();
    tick();
    check("t6_busy_mid", 64'(busy), 64'h1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'h0);
    check("t6_rst_flit", out_flit, 64'h0);
    check("t6_rst_vc", 64'(out_vc), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    for (int i = 0; i < 4; i++) fifo[i].delete();
    update_inputs();
    @(negedge clk);
    rst = 1'b1;
    push(1, mk(1, 1, 1, 40));
    push(0, mk(1, 1, 0, 41));
    #1;
    check("t6_vc0_first", 64'(vc_consume), 64'h1);
    tick();
    check("t6_vc0_out_vc", 64'(out_vc), 64'h0);
    tick();
    check("t6_vc1_next", 64'(cons), 64'h2);
    for (int k = 0; k < 8; k++) push(1, mk(1, 1, 1, 50 + k));
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("t6_credit_pop%0d", k), 64'(cons), 64'h2);
    end
    tick();
    check("t6_credit_limit", 64'(cons), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
